// File: rtl/div_unit.sv
// RV64M divide front-end (DIV/DIVU/REM/REMU + W forms) around a radix-2 restoring divider.
// Optional build macro DIV_UNIT_FASTPATH_EN: divide-by-zero ops skip the divider entirely.

module divu (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic [63:0] dividend_i,
  input  logic [63:0] divisor_i,
  output logic        data_ok_o,
  output logic [63:0] quotient_o,
  output logic [63:0] remainder_o
);
  logic        busy_q;
  logic        ok_q;
  logic [5:0]  cnt_q;
  logic [63:0] quo_q;
  logic [63:0] rem_q;
  logic [63:0] dsr_q;
  logic [64:0] shifted_d;
  logic [64:0] diff_d;
  logic        ge_d;

  always_comb begin
    shifted_d = {rem_q, quo_q[63]};
    diff_d    = shifted_d - {1'b0, dsr_q};
    ge_d      = !diff_d[64];
  end

  // Dropping valid_i is the only way to clear a finished or abandoned division.
  always_ff @(posedge clk) begin
    if (reset || !valid_i) begin
      busy_q <= 1'b0;
      ok_q   <= 1'b0;
      cnt_q  <= 6'd0;
    end else if (!busy_q && !ok_q) begin
      busy_q <= 1'b1;
      cnt_q  <= 6'd0;
      quo_q  <= dividend_i;
      rem_q  <= 64'd0;
      dsr_q  <= divisor_i;
    end else if (busy_q) begin
      rem_q <= ge_d ? diff_d[63:0] : shifted_d[63:0];
      quo_q <= {quo_q[62:0], ge_d};
      cnt_q <= cnt_q + 6'd1;
      if (cnt_q == 6'd63) begin
        busy_q <= 1'b0;
        ok_q   <= 1'b1;
      end
    end
  end

  assign data_ok_o   = ok_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
endmodule

module div_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic            is_word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      state_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [63:0] result_q;
  logic        dv_valid_q;
  logic [1:0]  op_q;
  logic        word_q;
  logic        sa_q;
  logic        sb_q;
  logic        bz_q;
  logic [63:0] a_ext_q;
  logic [63:0] a_mag_q;
  logic [63:0] b_mag_q;

  logic [63:0] a_ext_d;
  logic [63:0] b_ext_d;
  logic        sa_d;
  logic        sb_d;
  logic [63:0] a_mag_d;
  logic [63:0] b_mag_d;
  logic        bz_d;

  logic        dv_ok;
  logic [63:0] dv_quo;
  logic [63:0] dv_rem;
  logic [63:0] q_fix_d;
  logic [63:0] r_fix_d;
  logic [63:0] sel_d;
  logic [63:0] result_d;

  divu u_divu (
    .clk         (clk),
    .reset       (reset),
    .valid_i     (dv_valid_q),
    .dividend_i  (a_mag_q),
    .divisor_i   (b_mag_q),
    .data_ok_o   (dv_ok),
    .quotient_o  (dv_quo),
    .remainder_o (dv_rem)
  );

  // op[0] set means unsigned: zero-extend W operands and never take magnitudes.
  always_comb begin
    a_ext_d = src1;
    b_ext_d = src2;
    if (is_word) begin
      a_ext_d = op[0] ? {32'd0, src1[31:0]} : {{32{src1[31]}}, src1[31:0]};
      b_ext_d = op[0] ? {32'd0, src2[31:0]} : {{32{src2[31]}}, src2[31:0]};
    end
    sa_d    = !op[0] && a_ext_d[63];
    sb_d    = !op[0] && b_ext_d[63];
    a_mag_d = sa_d ? -a_ext_d : a_ext_d;
    b_mag_d = sb_d ? -b_ext_d : b_ext_d;
    bz_d    = (b_ext_d == 64'd0);
  end

  // MIN/-1 falls out of plain negation, so only divide-by-zero needs an override.
  always_comb begin
    q_fix_d = (sa_q ^ sb_q) ? -dv_quo : dv_quo;
    r_fix_d = sa_q ? -dv_rem : dv_rem;
    if (bz_q) begin
      q_fix_d = '1;
      r_fix_d = a_ext_q;
    end
    sel_d    = op_q[1] ? r_fix_d : q_fix_d;
    result_d = word_q ? {{32{sel_d[31]}}, sel_d[31:0]} : sel_d;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= 64'd0;
      dv_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q       <= op;
            word_q     <= is_word;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            bz_q       <= bz_d;
            a_ext_q    <= a_ext_d;
            a_mag_q    <= a_mag_d;
            b_mag_q    <= b_mag_d;
            in_ready_q <= 1'b0;
            state_q    <= S_BUSY;
`ifdef DIV_UNIT_FASTPATH_EN
            dv_valid_q <= !bz_d;
`else
            dv_valid_q <= 1'b1;
`endif
          end
        end
        S_BUSY: begin
`ifdef DIV_UNIT_FASTPATH_EN
          if (dv_ok || bz_q) begin
`else
          if (dv_ok) begin
`endif
            result_q    <= result_d;
            out_valid_q <= 1'b1;
            dv_valid_q  <= 1'b0;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: RISC-V arithmetic model, cycle-accurate scoreboard, literal pins.
module tb_div_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'd0;
  logic        is_word = 1'b0;
  logic [63:0] src1 = 64'd0;
  logic [63:0] src2 = 64'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;

  div_unit #(.XLEN(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .is_word   (is_word),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic        run = 1'b0;
  logic        ov_prev = 1'b0;
  logic [63:0] last_res = 64'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RISC-V M-extension semantics written directly with language arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    int                s32a, s32b;
    int unsigned       u32a, u32b;
    longint            s64a, s64b;
    longint unsigned   u64a, u64b;
    logic [31:0]       r32;
    logic [63:0]       r64;
    r32 = 32'd0;
    r64 = 64'd0;
    if (w) begin
      if (!o[0]) begin
        s32a = a[31:0];
        s32b = b[31:0];
        if (s32b == 0)                           r32 = o[1] ? s32a : 32'hFFFF_FFFF;
        else if (s32a == 32'sh8000_0000 && s32b == -1) r32 = o[1] ? 32'd0 : s32a;
        else                                     r32 = o[1] ? (s32a % s32b) : (s32a / s32b);
      end else begin
        u32a = a[31:0];
        u32b = b[31:0];
        if (u32b == 0) r32 = o[1] ? u32a : 32'hFFFF_FFFF;
        else           r32 = o[1] ? (u32a % u32b) : (u32a / u32b);
      end
      r64 = {{32{r32[31]}}, r32};
    end else begin
      if (!o[0]) begin
        s64a = a;
        s64b = b;
        if (s64b == 0)                                     r64 = o[1] ? s64a : '1;
        else if (s64a == 64'sh8000_0000_0000_0000 && s64b == -1) r64 = o[1] ? 64'd0 : s64a;
        else                                               r64 = o[1] ? (s64a % s64b) : (s64a / s64b);
      end else begin
        u64a = a;
        u64b = b;
        if (u64b == 0) r64 = o[1] ? u64a : '1;
        else           r64 = o[1] ? (u64a % u64b) : (u64a / u64b);
      end
    end
    return r64;
  endfunction

  // Single compare process: value every valid cycle, exact rise cycle, no spurious/late results.
  always @(negedge clk) begin
    if (run) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL spurious_out_valid: got result %h expected no output", result);
        end else begin
          check("result", result, exp_q[0].res);
          check("in_ready_while_done", {63'd0, in_ready}, 64'd0);
          if (!ov_prev) check("latency_cycle", 64'(cyc), 64'(exp_q[0].due));
          if (out_ready) begin
            last_res = result;
            $display("txn: result=%h at cycle %0d", result, cyc);
            void'(exp_q.pop_front());
          end
        end
      end else if (exp_q.size() != 0 && cyc == exp_q[0].due) begin
        check("out_valid_on_time", 64'd0, 64'd1);
      end
      ov_prev = out_valid;
    end
  end

  task automatic wait_in_ready();
    for (int i = 0; i < 200 && !in_ready; i++) @(negedge clk);
    if (!in_ready) check("in_ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_op(input logic [1:0] o, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic chk_lit, input logic [63:0] lit,
                       input int hold);
    logic [63:0] m;
    int          lat;
    m = model(o, w, a, b);
    if (chk_lit) check("model_pin", m, lit);
    wait_in_ready();
    lat = 66;
`ifdef DIV_UNIT_FASTPATH_EN
    if ((w ? {32'd0, b[31:0]} : b) == 64'd0) lat = 1;
`endif
    out_ready = (hold == 0);
    exp_q.push_back('{m, cyc + 1 + lat});
    op = o; is_word = w; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (hold > 0) begin
      for (int i = 0; i < 200 && !out_valid; i++) @(negedge clk);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("hold_out_valid", {63'd0, out_valid}, 64'd1);
        check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
    end
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check("result_timeout", 64'd0, 64'd1);
      exp_q.delete();
    end
    if (chk_lit) check("dut_literal", last_res, lit);
  endtask

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_result", result, 64'd0);
    run = 1'b1;

    do_op(2'd1, 1'b0, 64'd100, 64'd7, 1'b1, 64'd14, 0);
    do_op(2'd3, 1'b0, 64'd100, 64'd7, 1'b1, 64'd2, 0);
    do_op(2'd0, 1'b0, -64'sd7, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    do_op(2'd2, 1'b0, -64'sd7, 64'd2, 1'b1, ONES, 0);
    do_op(2'd0, 1'b0, MIN64, ONES, 1'b1, MIN64, 0);
    do_op(2'd2, 1'b0, MIN64, ONES, 1'b1, 64'd0, 0);
    do_op(2'd0, 1'b1, 64'd5, 64'd0, 1'b1, ONES, 0);
    do_op(2'd3, 1'b1, 64'h1_8000_0000, 64'd0, 1'b1, 64'hFFFF_FFFF_8000_0000, 0);
    do_op(2'd0, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_8000_0000, 0);
    do_op(2'd2, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 64'd0, 0);
    do_op(2'd0, 1'b0, 64'd7, -64'sd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    do_op(2'd2, 1'b0, 64'd7, -64'sd2, 1'b1, 64'd1, 0);
    do_op(2'd1, 1'b1, 64'hFFFF_FFFF, 64'd1, 1'b1, ONES, 0);
    do_op(2'd2, 1'b0, -64'sd5, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 0);
    do_op(2'd1, 1'b0, ONES, 64'd0, 1'b1, ONES, 0);

    // Flush mid-division: no result, unit idle again next cycle.
    wait_in_ready();
    op = 2'd1; is_word = 1'b0; src1 = 64'd100; src2 = 64'd7; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (30) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    repeat (80) @(negedge clk);
    do_op(2'd1, 1'b0, 64'd9, 64'd3, 1'b1, 64'd3, 0);

    // Flush together with a request in IDLE drops the request.
    wait_in_ready();
    op = 2'd1; src1 = 64'd50; src2 = 64'd5; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1 begin in_valid = 1'b0; flush = 1'b0; end
    @(negedge clk);
    check("flush_idle_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (80) @(negedge clk);

    // Result held under back-pressure.
    do_op(2'd1, 1'b0, 64'd100, 64'd7, 1'b1, 64'd14, 5);
    do_op(2'd0, 1'b1, 64'hFFFF_FFF9, 64'd2, 1'b1, ONES - 64'd2, 3);

    for (int i = 0; i < 6; i++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {32'd0, $urandom} >> $urandom_range(0, 28);
      do_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ra, rb, 1'b0, 64'd0, 0);
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
